// File: rtl/reg_bank8x16.sv
// reg_bank8x16: eight 16-bit registers with an addressed write/read port,
// parallel q0..q7 taps and a one-register-per-clock clear sweep.
// Optional macro REG_BANK8_READ_REG_EN: registers the read port (1-cycle latency,
// returns the pre-update value); otherwise out is a combinational mux.

// One storage word: sweep clear has priority over write.
module reg_bank8x16_lane (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        clr,
    input  logic [15:0] d,
    output logic [15:0] q
);
    // Hold, write, or zero the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= 16'h0000;
        else if (clr)
            q <= 16'h0000;
        else if (we)
            q <= d;
    end
endmodule

module reg_bank8x16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic [2:0]  address,
    input  logic        load,
    input  logic        clear,
    output logic [15:0] out,
    output logic [15:0] q0,
    output logic [15:0] q1,
    output logic [15:0] q2,
    output logic [15:0] q3,
    output logic [15:0] q4,
    output logic [15:0] q5,
    output logic [15:0] q6,
    output logic [15:0] q7,
    output logic        busy,
    output logic        drop
);
    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

    state_t           state;
    logic [2:0]       idx;
    logic [7:0][15:0] regs;
    logic [7:0]       we;
    logic [7:0]       clr;

    // Per-word strobes: a write only lands in IDLE without a competing clear.
    always_comb begin
        we  = '0;
        clr = '0;
        if (state == IDLE && !clear && load)
            we[address] = 1'b1;
        if (state == SWEEP)
            clr[idx] = 1'b1;
    end

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_lane
            reg_bank8x16_lane u_lane (
                .clk   (clk),
                .reset (reset),
                .we    (we[g]),
                .clr   (clr[g]),
                .d     (in),
                .q     (regs[g])
            );
        end
    endgenerate

    // Sweep sequencer; busy and drop are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= 3'd0;
            busy  <= 1'b0;
            drop  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A load in the same cycle as clear loses and is reported.
                    drop <= clear & load;
                    if (clear) begin
                        state <= SWEEP;
                        idx   <= 3'd0;
                        busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    // Loads are discarded; clear is neither queued nor restarts.
                    drop <= load;
                    if (idx == 3'd7) begin
                        state <= IDLE;
                        idx   <= 3'd0;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= 3'd0;
                    busy  <= 1'b0;
                    drop  <= 1'b0;
                end
            endcase
        end
    end

`ifdef REG_BANK8_READ_REG_EN
    // Registered read: captures the word before this edge's update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out <= 16'h0000;
        else
            out <= regs[address];
    end
`else
    // Combinational read straight off the selected word.
    assign out = regs[address];
`endif

    assign q0 = regs[0];
    assign q1 = regs[1];
    assign q2 = regs[2];
    assign q3 = regs[3];
    assign q4 = regs[4];
    assign q5 = regs[5];
    assign q6 = regs[6];
    assign q7 = regs[7];
endmodule

// File: tb/tb_reg_bank8x16.sv
// Bench for reg_bank8x16: directed scenarios then random traffic, all checked
// against a spec-level model of the bank (word array + sweep cycles remaining).
module tb_reg_bank8x16;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in = '0;
    logic [2:0]  address = '0;
    logic        load = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] out, q0, q1, q2, q3, q4, q5, q6, q7;
    logic        busy, drop;
    logic [15:0] qa [8];

    int n_vec = 0;
    int n_err = 0;

    // Model: bank contents, remaining sweep edges (0 = idle), expected drop/out.
    logic [15:0] m_bank [8];
    int          m_left;
    logic        m_drop;
    logic [15:0] m_out_reg;

    reg_bank8x16 dut (
        .clk(clk), .reset(reset), .in(in), .address(address), .load(load),
        .clear(clear), .out(out), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .q4(q4), .q5(q5), .q6(q6), .q7(q7), .busy(busy), .drop(drop)
    );

    always #5 clk = ~clk;

    assign qa[0] = q0; assign qa[1] = q1; assign qa[2] = q2; assign qa[3] = q3;
    assign qa[4] = q4; assign qa[5] = q5; assign qa[6] = q6; assign qa[7] = q7;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_bank[i] = 16'h0;
        m_left = 0;
        m_drop = 1'b0;
        m_out_reg = 16'h0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s.q%0d", tag, i), qa[i], m_bank[i]);
        chk({tag, ".busy"}, {15'd0, busy}, {15'd0, m_left != 0});
        chk({tag, ".drop"}, {15'd0, drop}, {15'd0, m_drop});
`ifdef REG_BANK8_READ_REG_EN
        chk({tag, ".out"}, out, m_out_reg);
`else
        chk({tag, ".out"}, out, m_bank[address]);
`endif
    endtask

    // Apply one cycle of inputs, update the model from spec rules, check after the edge.
    task automatic step(input string tag, input logic ld, input logic cl,
                        input logic [2:0] a, input logic [15:0] d);
        load = ld; clear = cl; address = a; in = d;
        @(posedge clk);
        m_out_reg = m_bank[a];
        if (m_left != 0) begin
            m_bank[8 - m_left] = 16'h0;     // sweep reaches words in ascending order
            m_left--;
            m_drop = ld;
        end else if (cl) begin
            m_left = 8;
            m_drop = ld;
        end else begin
            if (ld) m_bank[a] = d;
            m_drop = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, address, 16'h0);
    endtask

    initial begin
        logic [15:0] orv;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Two writes feed the downstream OR reducer.
        step("wr3", 1'b1, 1'b0, 3'd3, 16'h1234);
        step("wr7", 1'b1, 1'b0, 3'd7, 16'h8001);
        orv = q0 | q1 | q2 | q3 | q4 | q5 | q6 | q7;
        chk("or_summary", orv, 16'h9235);

        // Full preload then a one-cycle clear.
        for (int i = 0; i < 8; i++) step("pre", 1'b1, 1'b0, 3'(i), 16'hFFFF);
        step("clr", 1'b0, 1'b1, 3'd0, 16'h0);
        idle("sweep", 8);
        chk("sweep_done_or", q0 | q1 | q2 | q3 | q4 | q5 | q6 | q7, 16'h0);

        // Load + clear during sweep, 3 cycles after clear, plus clear at E8.
        for (int i = 0; i < 8; i++) step("pre2", 1'b1, 1'b0, 3'(i), 16'hA5A5);
        step("clr2", 1'b0, 1'b1, 3'd0, 16'h0);
        idle("sw2", 2);
        step("ld_in_sweep", 1'b1, 1'b1, 3'd5, 16'h00AA);
        idle("sw2b", 4);
        step("clr_at_e8", 1'b0, 1'b1, 3'd0, 16'h0);
        chk("reg5_zero", q5, 16'h0);
        step("first_load", 1'b1, 1'b0, 3'd4, 16'h4444);

        // clear and load collide in IDLE.
        step("wr2", 1'b1, 1'b0, 3'd2, 16'h0202);
        step("clr_ld", 1'b1, 1'b1, 3'd2, 16'h5555);
        idle("sw3", 8);

        // Asynchronous reset during sweep cycle 4.
        for (int i = 0; i < 8; i++) step("pre3", 1'b1, 1'b0, 3'(i), 16'h3C3C + 16'(i));
        step("clr4", 1'b0, 1'b1, 3'd6, 16'h0);
        idle("sw4", 3);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #1 reset = 1'b0;
        step("post_rst_ld", 1'b1, 1'b0, 3'd6, 16'h6666);
        idle("post_rst", 1);

        // Read port: address 1 holds 0x0F0F, then 0x7777 is written.
        step("rd_pre", 1'b1, 1'b0, 3'd1, 16'h0F0F);
        step("rd_hold", 1'b0, 1'b0, 3'd1, 16'h0);
        step("rd_wr", 1'b1, 1'b0, 3'd1, 16'h7777);
`ifdef REG_BANK8_READ_REG_EN
        chk("rd_reg_e", out, 16'h0F0F);
        step("rd_e1", 1'b0, 1'b0, 3'd1, 16'h0);
        chk("rd_reg_e1", out, 16'h7777);
`else
        chk("rd_comb_e", out, 16'h7777);
`endif

        // Random traffic; clears are rare so IDLE writes dominate.
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
                 3'($urandom_range(0, 7)), 16'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
